uncache_axi_bridge: RTL

- Responder for the uncached-access request interface. It accepts the rd_req/wr_req handshake from the uncache front-end, returns rd_rdy, wr_rdy, ret_valid and ret_data, and masters single-beat AXI4 transactions.
- Sits between the uncache front-end and the AXI crossbar.
- Strictly in-order: at most one transaction (read or write) is outstanding, which guarantees MMIO ordering.

---
 rtl/uncache_axi_bridge_if.sv | 58 +++++
 rtl/uncache_axi_bridge.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uncache_axi_bridge_if.sv
// AXI4 bus bundle between the uncache bridge (master) and the crossbar port (slave).
interface uncache_axi_bridge_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/uncache_axi_bridge.sv
// Uncached request responder issuing single-beat, strictly in-order AXI4 transactions.
// Optional macro UNCACHE_AXI_BRIDGE_RESP_ERR_EN adds bus_err/err_addr reporting of non-OKAY responses.
module uncache_axi_bridge #(
  parameter logic [3:0]  AXI_ID         = 4'd1,
  parameter logic [31:0] RESET_ADDR_VAL = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  input  logic [2:0]  axi_arsize,
  output logic        rd_rdy,
  output logic        ret_valid,
  output logic [31:0] ret_data,
  input  logic        wr_req,
  input  logic [31:0] wr_addr,
  input  logic [2:0]  axi_awsize,
  input  logic [3:0]  axi_wstrb,
  input  logic [31:0] wr_data,
  output logic        wr_rdy,
`ifdef UNCACHE_AXI_BRIDGE_RESP_ERR_EN
  output logic        bus_err,
  output logic [31:0] err_addr,
`endif
  output logic [2:0]  dbg_state,
  uncache_axi_bridge_if.master axi
);

  // Handshake rule: a transfer happens on a rising edge where valid and ready are
  // both high; a valid, once raised, holds with stable payload until that edge.
  typedef enum logic [2:0] {IDLE, AR, R, RET, AWW, B} state_t;

  state_t      state, state_n;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  size_q;
  logic [3:0]  wstrb_q;
  logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic        arvalid_n, rready_n, awvalid_n, wvalid_n, bready_n;
  logic        rd_acc, wr_acc;
  logic        unused_ok;

  // Ready depends on rd_req nowhere, so the front-end can derive rd_req from rd_rdy.
  assign wr_rdy    = (state == IDLE);
  assign rd_rdy    = (state == IDLE) & ~wr_req;
  assign wr_acc    = wr_req & wr_rdy;
  assign rd_acc    = rd_req & rd_rdy;
  assign ret_valid = (state == RET);
  assign dbg_state = state;

  assign axi.arid    = AXI_ID;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = size_q;
  assign axi.arburst = 2'b01;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;
  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = size_q;
  assign axi.awburst = 2'b01;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;

  assign unused_ok = ^{axi.rid, axi.rlast, axi.bid, axi.rresp, axi.bresp};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    arvalid_n = arvalid_q;
    rready_n  = rready_q;
    awvalid_n = awvalid_q;
    wvalid_n  = wvalid_q;
    bready_n  = bready_q;
    case (state)
      IDLE: begin
        if (wr_acc) begin
          state_n   = AWW;
          awvalid_n = 1'b1;
          wvalid_n  = 1'b1;
        end else if (rd_acc) begin
          state_n   = AR;
          arvalid_n = 1'b1;
        end
      end
      AR: begin
        if (axi.arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = R;
        end
      end
      R: begin
        if (axi.rvalid) begin
          rready_n = 1'b0;
          state_n  = RET;
        end
      end
      RET: state_n = IDLE;
      AWW: begin
        // AW and W complete independently; leave once neither is still pending.
        if (axi.awready) awvalid_n = 1'b0;
        if (axi.wready)  wvalid_n  = 1'b0;
        if (!awvalid_n && !wvalid_n) begin
          bready_n = 1'b1;
          state_n  = B;
        end
      end
      B: begin
        if (axi.bvalid) begin
          bready_n = 1'b0;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      arvalid_q <= arvalid_n;
      rready_q  <= rready_n;
      awvalid_q <= awvalid_n;
      wvalid_q  <= wvalid_n;
      bready_q  <= bready_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= RESET_ADDR_VAL;
      size_q   <= 3'd0;
      wstrb_q  <= 4'd0;
      wdata_q  <= 32'd0;
      ret_data <= 32'd0;
    end else begin
      if (wr_acc) begin
        addr_q  <= wr_addr;
        size_q  <= axi_awsize;
        wstrb_q <= axi_wstrb;
        wdata_q <= wr_data;
      end else if (rd_acc) begin
        addr_q <= rd_addr;
        size_q <= axi_arsize;
      end
      if (state == R && axi.rvalid) ret_data <= axi.rdata;
    end
  end

`ifdef UNCACHE_AXI_BRIDGE_RESP_ERR_EN
  // Read errors line up with the RET cycle, write errors with the IDLE-return cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_err  <= 1'b0;
      err_addr <= 32'd0;
    end else begin
      bus_err <= 1'b0;
      if (state == R && axi.rvalid && axi.rresp != 2'b00) begin
        bus_err  <= 1'b1;
        err_addr <= addr_q;
      end else if (state == B && axi.bvalid && axi.bresp != 2'b00) begin
        bus_err  <= 1'b1;
        err_addr <= addr_q;
      end
    end
  end
`endif

endmodule
